// File: rtl/ysyx_22050710_sram_arbiter_pkg.sv
// Shared constants for the SRAM-like bus arbiter: master IDs and size codes.
package ysyx_22050710_sram_arbiter_pkg;

  // Owner ID stored in the in-order response FIFO.
  typedef logic mst_t;

  localparam mst_t MST_INST = 1'b0;
  localparam mst_t MST_DATA = 1'b1;

  // Transfer size codes carried on the *_size buses.
  localparam logic [1:0] SIZE_B = 2'd0;  // 1 byte
  localparam logic [1:0] SIZE_H = 2'd1;  // 2 bytes
  localparam logic [1:0] SIZE_W = 2'd2;  // 4 bytes
  localparam logic [1:0] SIZE_D = 2'd3;  // 8 bytes

endpackage

// File: rtl/ysyx_22050710_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs for requests accepted by the slave
// but not yet answered with data_ok.
module ysyx_22050710_owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_din,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = PTR_WD + 1;
  localparam logic [PTR_WD-1:0] PTR_ONE = PTR_WD'(1);
  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);
  localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(DEPTH);

  logic              r_mem [DEPTH];
  logic [PTR_WD-1:0] r_wr_ptr;
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [CNT_WD-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_MAX);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Owner storage write port.
  // NOTE: storage has no reset; an entry is only read while the count says it is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/ysyx_22050710_sram_arbiter.sv
// Two-master (inst/data) to one-slave arbiter on the SRAM-like req/addr_ok/data_ok
// bus. Data has priority unless a stalled request holds the lock; responses are
// steered back in order using the owner FIFO.
module ysyx_22050710_sram_arbiter
  import ysyx_22050710_sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDR_WD  = 32,
  parameter int SRAM_WMASK_WD = 8,
  parameter int SRAM_DATA_WD  = 64,
  parameter int OUTSTANDING   = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  // inst master
  input  logic                     i_inst_req,
  input  logic                     i_inst_wr,
  input  logic [1:0]               i_inst_size,
  input  logic [SRAM_ADDR_WD-1:0]  i_inst_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_inst_wstrb,
  input  logic [SRAM_DATA_WD-1:0]  i_inst_wdata,
  output logic                     o_inst_addr_ok,
  output logic                     o_inst_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_inst_rdata,
  // data master
  input  logic                     i_data_req,
  input  logic                     i_data_wr,
  input  logic [1:0]               i_data_size,
  input  logic [SRAM_ADDR_WD-1:0]  i_data_addr,
  input  logic [SRAM_WMASK_WD-1:0] i_data_wstrb,
  input  logic [SRAM_DATA_WD-1:0]  i_data_wdata,
  output logic                     o_data_addr_ok,
  output logic                     o_data_data_ok,
  output logic [SRAM_DATA_WD-1:0]  o_data_rdata,
  // slave
  output logic                     o_sram_req,
  output logic                     o_sram_wr,
  output logic [1:0]               o_sram_size,
  output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
  output logic [SRAM_WMASK_WD-1:0] o_sram_wstrb,
  output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
  input  logic                     i_sram_addr_ok,
  input  logic                     i_sram_data_ok,
  input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata,
  // status
  output logic                     o_resp_err
);

  mst_t r_lock_owner;
  logic r_lock_valid;
  logic r_resp_err;

  mst_t w_grant;
  logic w_grant_req;
  logic w_full;
  logic w_empty;
  mst_t w_head;
  logic w_accept;
  logic w_pop;

  // Pick the master that drives the slave this cycle.
  always_comb begin
    // NOTE: every path assigns w_grant, so no latch is inferred.
    w_grant = MST_INST;
    if (r_lock_valid)    w_grant = r_lock_owner;
    else if (i_data_req) w_grant = MST_DATA;
  end

  // Zero-latency mux of the granted master's request payload onto the slave.
  always_comb begin
    if (w_grant == MST_DATA) begin
      w_grant_req  = i_data_req;
      o_sram_wr    = i_data_wr;
      o_sram_size  = i_data_size;
      o_sram_addr  = i_data_addr;
      o_sram_wstrb = i_data_wstrb;
      o_sram_wdata = i_data_wdata;
    end else begin
      w_grant_req  = i_inst_req;
      o_sram_wr    = i_inst_wr;
      o_sram_size  = i_inst_size;
      o_sram_addr  = i_inst_addr;
      o_sram_wstrb = i_inst_wstrb;
      o_sram_wdata = i_inst_wdata;
    end
  end

  // Request is withheld while the FIFO is full or reset is asserted.
  assign o_sram_req     = w_grant_req & ~w_full & ~i_rst;
  assign w_accept       = o_sram_req & i_sram_addr_ok;
  assign o_inst_addr_ok = w_accept & (w_grant == MST_INST);
  assign o_data_addr_ok = w_accept & (w_grant == MST_DATA);

  // Responses go to the FIFO head owner; data_ok on an empty FIFO is dropped.
  assign w_pop          = i_sram_data_ok & ~w_empty;
  assign o_inst_data_ok = w_pop & (w_head == MST_INST);
  assign o_data_data_ok = w_pop & (w_head == MST_DATA);
  assign o_inst_rdata   = i_sram_rdata;
  assign o_data_rdata   = i_sram_rdata;
  assign o_resp_err     = r_resp_err;

  ysyx_22050710_owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_din   (w_grant),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Hold the grant on a presented-but-not-accepted request until it is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_valid <= 1'b0;
      r_lock_owner <= MST_INST;
    end else if (w_accept) begin
      r_lock_valid <= 1'b0;
    end else if (o_sram_req) begin
      r_lock_valid <= 1'b1;
      r_lock_owner <= w_grant;
    end else if (r_lock_valid && !w_grant_req) begin
      // Owner withdrew its request; release rather than wedge the bus.
      r_lock_valid <= 1'b0;
    end
  end

  // Sticky flag for a data_ok that had no outstanding request to match.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           r_resp_err <= 1'b0;
    else if (i_sram_data_ok && w_empty)  r_resp_err <= 1'b1;
  end

endmodule

// File: tb/tb_ysyx_22050710_sram_arbiter.sv
// Directed bench for the inst/data SRAM arbiter with an in-order owner scoreboard.
module tb_ysyx_22050710_sram_arbiter;
  import ysyx_22050710_sram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, data_addr;
  logic [7:0]  inst_wstrb, data_wstrb;
  logic [63:0] inst_wdata, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [63:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr;
  logic [7:0]  sram_wstrb;
  logic [63:0] sram_wdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [63:0] sram_rdata;
  logic        resp_err;

  int   n_total = 0;
  int   n_pass  = 0;
  mst_t sb[$];

  always #5 clk = ~clk;

  ysyx_22050710_sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_wr(inst_wr), .i_inst_size(inst_size),
    .i_inst_addr(inst_addr), .i_inst_wstrb(inst_wstrb), .i_inst_wdata(inst_wdata),
    .o_inst_addr_ok(inst_addr_ok), .o_inst_data_ok(inst_data_ok), .o_inst_rdata(inst_rdata),
    .i_data_req(data_req), .i_data_wr(data_wr), .i_data_size(data_size),
    .i_data_addr(data_addr), .i_data_wstrb(data_wstrb), .i_data_wdata(data_wdata),
    .o_data_addr_ok(data_addr_ok), .o_data_data_ok(data_data_ok), .o_data_rdata(data_rdata),
    .o_sram_req(sram_req), .o_sram_wr(sram_wr), .o_sram_size(sram_size),
    .o_sram_addr(sram_addr), .o_sram_wstrb(sram_wstrb), .o_sram_wdata(sram_wdata),
    .i_sram_addr_ok(sram_addr_ok), .i_sram_data_ok(sram_data_ok), .i_sram_rdata(sram_rdata),
    .o_resp_err(resp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Compare the response currently on the bus against the scoreboard head.
  task automatic check_resp(input string tag, input logic [63:0] rdata);
    mst_t exp_owner;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    exp_owner = (sb.size() != 0) ? sb.pop_front() : MST_INST;
    check({tag, "_inst_data_ok"}, 64'(inst_data_ok), 64'(exp_owner == MST_INST));
    check({tag, "_data_data_ok"}, 64'(data_data_ok), 64'(exp_owner == MST_DATA));
    if (exp_owner == MST_DATA) check({tag, "_data_rdata"}, data_rdata, rdata);
    else                       check({tag, "_inst_rdata"}, inst_rdata, rdata);
  endtask

  task automatic respond(input string tag, input logic [63:0] rdata);
    sram_data_ok = 1'b1;
    sram_rdata   = rdata;
    #1;
    check_resp(tag, rdata);
    nxt();
    sram_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_D; inst_addr = 32'h0;
    inst_wstrb = 8'h00; inst_wdata = 64'h0;
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_W; data_addr = 32'h0;
    data_wstrb = 8'h0f; data_wdata = 64'hdead_beef;
    sram_addr_ok = 1'b1; sram_data_ok = 1'b0; sram_rdata = 64'h0;

    // Reset: handshakes held low even with requests pending.
    #2;
    check("rst_sram_req", 64'(sram_req), 64'd0);
    check("rst_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    check("rst_data_addr_ok", 64'(data_addr_ok), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    nxt();
    rst = 1'b0; inst_req = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0;
    #1;
    check("post_rst_sram_req", 64'(sram_req), 64'd0);
    check("post_rst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);

    // Priority: both request, data first, inst next cycle, in-order responses.
    nxt();
    inst_req = 1'b1; inst_addr = 32'h2000;
    data_req = 1'b1; data_addr = 32'h1000;
    sram_addr_ok = 1'b1;
    #1;
    check("pri_data_addr_ok", 64'(data_addr_ok), 64'd1);
    check("pri_inst_addr_ok", 64'(inst_addr_ok), 64'd0);
    check("pri_addr", 64'(sram_addr), 64'h1000);
    check("pri_wr", 64'(sram_wr), 64'd1);
    check("pri_wstrb", 64'(sram_wstrb), 64'h0f);
    sb.push_back(MST_DATA);
    nxt();
    data_req = 1'b0;
    #1;
    check("pri2_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    check("pri2_addr", 64'(sram_addr), 64'h2000);
    check("pri2_size", 64'(sram_size), 64'(SIZE_D));
    sb.push_back(MST_INST);
    nxt();
    inst_req = 1'b0; sram_addr_ok = 1'b0;
    respond("pri_r0", 64'hAA);
    respond("pri_r1", 64'hBB);

    // Lock: stalled inst request is not preempted by a later data request.
    inst_req = 1'b1; inst_addr = 32'h3000;
    #1;
    check("lock_c0_req", 64'(sram_req), 64'd1);
    check("lock_c0_addr", 64'(sram_addr), 64'h3000);
    nxt();
    data_req = 1'b1; data_addr = 32'h4000;
    #1;
    check("lock_c1_addr", 64'(sram_addr), 64'h3000);
    check("lock_c1_data_addr_ok", 64'(data_addr_ok), 64'd0);
    nxt();
    #1;
    check("lock_c2_addr", 64'(sram_addr), 64'h3000);
    nxt();
    sram_addr_ok = 1'b1;
    #1;
    check("lock_acc_inst_addr_ok", 64'(inst_addr_ok), 64'd1);
    check("lock_acc_data_addr_ok", 64'(data_addr_ok), 64'd0);
    sb.push_back(MST_INST);
    nxt();
    inst_req = 1'b0;
    #1;
    check("lock_next_addr", 64'(sram_addr), 64'h4000);
    check("lock_next_data_addr_ok", 64'(data_addr_ok), 64'd1);
    sb.push_back(MST_DATA);
    nxt();
    data_req = 1'b0; sram_addr_ok = 1'b0;
    respond("lock_r0", 64'h11);
    respond("lock_r1", 64'h22);

    // Full: four accepts, then the request is gated until a slot frees.
    data_req = 1'b1; data_addr = 32'h5000; sram_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("full_fill%0d", i), 64'(data_addr_ok), 64'd1);
      sb.push_back(MST_DATA);
      nxt();
    end
    #1;
    check("full_req_gated", 64'(sram_req), 64'd0);
    check("full_addr_ok_gated", 64'(data_addr_ok), 64'd0);
    nxt();
    sram_data_ok = 1'b1; sram_rdata = 64'h33;
    #1;
    check("full_no_bypass", 64'(sram_req), 64'd0);
    check_resp("full_r0", 64'h33);
    nxt();
    sram_data_ok = 1'b0;
    #1;
    check("full_req_back", 64'(sram_req), 64'd1);
    check("full_refill_addr_ok", 64'(data_addr_ok), 64'd1);
    sb.push_back(MST_DATA);
    nxt();
    data_req = 1'b0; sram_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) respond($sformatf("full_drain%0d", i), 64'h40 + 64'(i));

    // Concurrent push/pop at count 2 across pointer wrap.
    inst_req = 1'b1; inst_addr = 32'h6000; sram_addr_ok = 1'b1;
    #1;
    check("cc_pre0", 64'(inst_addr_ok), 64'd1);
    sb.push_back(MST_INST);
    nxt();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h7000;
    #1;
    check("cc_pre1", 64'(data_addr_ok), 64'd1);
    sb.push_back(MST_DATA);
    nxt();
    for (int i = 0; i < 10; i++) begin
      inst_req = ~i[0]; data_req = i[0];
      sram_data_ok = 1'b1; sram_rdata = 64'h100 + 64'(i);
      #1;
      check($sformatf("cc%0d_req", i), 64'(sram_req), 64'd1);
      check_resp($sformatf("cc%0d", i), 64'h100 + 64'(i));
      if (i[0]) check($sformatf("cc%0d_data_addr_ok", i), 64'(data_addr_ok), 64'd1);
      else      check($sformatf("cc%0d_inst_addr_ok", i), 64'(inst_addr_ok), 64'd1);
      sb.push_back(i[0] ? MST_DATA : MST_INST);
      nxt();
    end
    inst_req = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0; sram_data_ok = 1'b0;
    respond("cc_drain0", 64'h200);
    respond("cc_drain1", 64'h201);

    // Spurious data_ok on an empty FIFO: dropped and flagged stickily.
    sram_data_ok = 1'b1; sram_rdata = 64'h999;
    #1;
    check("err_no_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
    check("err_not_yet", 64'(resp_err), 64'd0);
    nxt();
    sram_data_ok = 1'b0;
    check("err_set", 64'(resp_err), 64'd1);
    nxt();
    nxt();
    check("err_sticky", 64'(resp_err), 64'd1);

    // Reset pulse with three outstanding requests.
    data_req = 1'b1; data_addr = 32'h8000; sram_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("rp_fill%0d", i), 64'(data_addr_ok), 64'd1);
      nxt();
    end
    sram_data_ok = 1'b1;
    rst = 1'b1;
    #1;
    check("rp_sram_req", 64'(sram_req), 64'd0);
    check("rp_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'd0);
    check("rp_data_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
    check("rp_resp_err", 64'(resp_err), 64'd0);
    sb.delete();
    nxt();
    rst = 1'b0; data_req = 1'b0; sram_addr_ok = 1'b0;
    #1;
    check("rp_after_empty", 64'({inst_data_ok, data_data_ok}), 64'd0);
    nxt();
    sram_data_ok = 1'b0;
    data_req = 1'b1; sram_addr_ok = 1'b1;
    #1;
    check("rp_new_accept", 64'(data_addr_ok), 64'd1);
    sb.push_back(MST_DATA);
    nxt();
    data_req = 1'b0; sram_addr_ok = 1'b0;
    respond("rp_new_resp", 64'h5A5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22050710_sram_arbiter.md
Name: ysyx_22050710_sram_arbiter

Overview:
- Two-master to one-slave arbiter on the SRAM-like (req/addr_ok/data_ok) bus.
- Shares a single memory port between the fetch stage (inst master) and the execute stage (data master).
- Tracks up to OUTSTANDING accepted-but-unanswered requests in an in-order owner FIFO.
- Steers each data_ok/rdata back to the master that issued the request; sits between the core pipeline and the memory/bridge.

Parameters:
- SRAM_ADDR_WD, 32, request address width
- SRAM_WMASK_WD, 8, write byte-strobe width
- SRAM_DATA_WD, 64, read/write data width
- OUTSTANDING, 4, max in-flight requests; power of 2, >=2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-high reset
- i_inst_req / i_inst_wr  in  1/1  inst master request, write flag
- i_inst_size  in  2  bytes code: 0:1, 1:2, 2:4, 3:8
- i_inst_addr / i_inst_wstrb / i_inst_wdata  in  SRAM_ADDR_WD/SRAM_WMASK_WD/SRAM_DATA_WD  inst request payload
- o_inst_addr_ok / o_inst_data_ok  out  1/1  inst handshakes
- o_inst_rdata  out  SRAM_DATA_WD  read data
- i_data_req, i_data_wr, i_data_size, i_data_addr, i_data_wstrb, i_data_wdata  in  same widths as inst  data master request
- o_data_addr_ok / o_data_data_ok  out  1/1; o_data_rdata  out  SRAM_DATA_WD
- o_sram_req, o_sram_wr  out  1/1; o_sram_size  out  2; o_sram_addr, o_sram_wstrb, o_sram_wdata  out  payload widths  slave request
- i_sram_addr_ok, i_sram_data_ok  in  1/1; i_sram_rdata  in  SRAM_DATA_WD  slave response
- o_resp_err  out  1  sticky: data_ok arrived with no outstanding request

Behaviour:
- Reset (async, i_rst=1): FIFO empty (count=0, pointers 0), lock cleared, o_resp_err=0. All req/addr_ok/data_ok outputs 0 during and right after reset.
- Grant (combinational):
  - If locked, grant = lock owner.
  - Else if i_data_req=1, grant = data master (data has priority).
  - Else grant = inst master.
- Slave request path:
  - o_sram_req = granted master's req AND !full, where full = (count==OUTSTANDING).
  - o_sram_wr/size/addr/wstrb/wdata = granted master's fields, muxed combinationally, zero latency.
- Address handshake:
  - o_<granted>_addr_ok = i_sram_addr_ok AND o_sram_req.
  - Non-granted master's addr_ok = 0.
  - Accept = o_sram_req & i_sram_addr_ok: push granted owner ID into the FIFO.
- Lock (holds a pending request stable until accepted):
  - At a clock edge with o_sram_req=1 and i_sram_addr_ok=0: lock_valid<=1, lock_owner<=grant.
  - Cleared on the accept edge.
  - Also cleared if the locked master's req is 0 (protocol violation, no hang).
  - While locked, a newly raised data request does not preempt inst.
- Full: no slave req and no addr_ok to either master. Lock is not set while full. A dequeue in the same cycle does not open a slot until the next cycle (no full-bypass).
- Response path:
  - FIFO head owner selects the destination.
  - o_<head>_data_ok = i_sram_data_ok AND !empty; the other master gets 0.
  - i_sram_rdata is broadcast to both rdata outputs, valid only with data_ok.
  - Writes also return data_ok and dequeue. Responses are strictly in order.
- Simultaneous accept and data_ok: push and pop in the same cycle; count unchanged; both pointers advance with wrap modulo OUTSTANDING.
- data_ok while empty: ignored (no data_ok to either master), o_resp_err<=1 until reset.
- Accept when count==OUTSTANDING cannot occur (req gated).

Decomposition:
- Shared package holds:
  - MST_INST=1'b0, MST_DATA=1'b1 owner-ID constants
  - size encoding constants (SIZE_B/H/W/D)
- Sub-module ysyx_22050710_owner_fifo: 1-bit-wide, OUTSTANDING-deep, push/pop/full/empty/head. Async-reset pointers and count of width $clog2(OUTSTANDING)+1.

Test Plan:
- Both reqs at cycle 0, addr_ok=1 -> data accepted first (o_data_addr_ok=1, o_inst_addr_ok=0). Inst accepted next cycle. data_ok at cycles 3,4 -> o_data_data_ok then o_inst_data_ok, rdata 0xAA then 0xBB.
- Inst req, addr_ok held 0 for 3 cycles, data req raised at cycle 1 -> o_sram_addr stays inst address until addr_ok. Data is granted the following cycle.
- 4 accepted requests with no data_ok -> count=4, o_sram_req=0 though i_data_req=1. One data_ok -> req reappears the next cycle.
- Accept and data_ok in the same cycle with count=2 -> count stays 2. Routing is correct across pointer wrap after 10 such cycles.
- i_sram_data_ok=1 with FIFO empty -> both data_ok=0, o_resp_err=1 and sticky. i_rst pulse mid-traffic with 3 outstanding -> FIFO empty, o_resp_err=0, outputs 0 immediately.
